// File: rtl/id_scoreboard_fwd.sv
// Decode-stage register hazard unit: ordered forwarding sources plus a per-register in-flight writer scoreboard.
// Define SB_FWD_EN for forwarding; without it the unit is a pure interlock that reads only the regfile.
module id_scoreboard_fwd #(
  parameter int NREG = 32,
  parameter int AW   = 5,
  parameter int DW   = 32,
  parameter int NSRC = 3,
  parameter int CW   = 2
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic [1:0]           rs_need,
  input  logic [AW-1:0]        rs1_addr,
  input  logic [AW-1:0]        rs2_addr,
  input  logic [DW-1:0]        rf_rdata1,
  input  logic [DW-1:0]        rf_rdata2,
  input  logic [NSRC-1:0]      src_valid,
  input  logic [NSRC-1:0]      src_we,
  input  logic [NSRC*AW-1:0]   src_waddr,
  input  logic [NSRC-1:0]      src_ready,
  input  logic [NSRC*DW-1:0]   src_wdata,
  input  logic                 dst_we,
  input  logic [AW-1:0]        dst_waddr,
  input  logic                 issue_fire,
  input  logic                 retire_we,
  input  logic [AW-1:0]        retire_waddr,
  input  logic                 flush_all,
  output logic [DW-1:0]        rs1_value,
  output logic [DW-1:0]        rs2_value,
  output logic                 stall,
  output logic                 sb_err
);

  localparam logic [CW-1:0] PEND_MAX = '1;

  logic [CW-1:0] pend     [NREG];
  logic [CW-1:0] pend_nxt [NREG];
  logic          err_set;
  logic          block1;
  logic          block2;
  logic          dst_full;

  // Entry 0 stays zero so the zero register never looks pending.
  always_comb begin : counter_next
    logic inc_hit;
    logic dec_hit;
    err_set     = 1'b0;
    pend_nxt[0] = '0;
    for (int r = 1; r < NREG; r++) begin
      inc_hit     = issue_fire && dst_we && (dst_waddr == AW'(r));
      dec_hit     = retire_we && (retire_waddr == AW'(r));
      pend_nxt[r] = pend[r];
      if (inc_hit && !dec_hit) begin
        if (pend[r] == PEND_MAX) err_set = 1'b1;
        else                     pend_nxt[r] = pend[r] + 1'b1;
      end else if (dec_hit && !inc_hit) begin
        if (pend[r] == '0) err_set = 1'b1;
        else               pend_nxt[r] = pend[r] - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      for (int r = 0; r < NREG; r++) pend[r] <= '0;
      sb_err <= 1'b0;
    end else if (flush_all) begin
      for (int r = 0; r < NREG; r++) pend[r] <= '0;
    end else begin
      pend <= pend_nxt;
      if (err_set) sb_err <= 1'b1;
    end
  end

`ifdef SB_FWD_EN
  typedef struct packed {
    logic          hit;
    logic          ready;
    logic [DW-1:0] data;
  } pick_t;

  // Walk oldest to youngest so the youngest matching source overrides.
  function automatic pick_t pick_src(input logic [AW-1:0] addr);
    pick_t p;
    p = '0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (src_valid[i] && src_we[i] && (src_waddr[i*AW +: AW] == addr) && (addr != '0)) begin
        p.hit   = 1'b1;
        p.ready = src_ready[i];
        p.data  = src_wdata[i*DW +: DW];
      end
    end
    return p;
  endfunction

  pick_t pick1;
  pick_t pick2;

  always_comb begin
    pick1     = pick_src(rs1_addr);
    pick2     = pick_src(rs2_addr);
    rs1_value = (rs1_addr == '0) ? '0 : (pick1.hit ? pick1.data : rf_rdata1);
    rs2_value = (rs2_addr == '0) ? '0 : (pick2.hit ? pick2.data : rf_rdata2);
    block1    = rs_need[0] && (rs1_addr != '0) &&
                (pick1.hit ? !pick1.ready : (pend[rs1_addr] != '0));
    block2    = rs_need[1] && (rs2_addr != '0) &&
                (pick2.hit ? !pick2.ready : (pend[rs2_addr] != '0));
  end
`else
  logic unused_src;

  // Without forwarding a pending writer blocks even in its retire cycle.
  always_comb begin
    rs1_value  = rf_rdata1;
    rs2_value  = rf_rdata2;
    block1     = rs_need[0] && (rs1_addr != '0) && (pend[rs1_addr] != '0);
    block2     = rs_need[1] && (rs2_addr != '0) && (pend[rs2_addr] != '0);
    unused_src = ^{src_valid, src_we, src_waddr, src_ready, src_wdata};
  end
`endif

  assign dst_full = dst_we && (dst_waddr != '0) && (pend[dst_waddr] == PEND_MAX);
  assign stall    = block1 || block2 || dst_full;

endmodule

// File: tb/tb_id_scoreboard_fwd.sv
// Randomised and directed bench for id_scoreboard_fwd against a behavioural hazard model.
`timescale 1ns/1ps
module tb_id_scoreboard_fwd;
  localparam int NREG = 32;
  localparam int AW   = 5;
  localparam int DW   = 32;
  localparam int NSRC = 3;
  localparam int CW   = 2;
  localparam int PMAX = (1 << CW) - 1;

  logic               clk = 1'b0;
  logic               resetn;
  logic [1:0]         rs_need;
  logic [AW-1:0]      rs1_addr, rs2_addr;
  logic [DW-1:0]      rf_rdata1, rf_rdata2;
  logic [NSRC-1:0]    src_valid, src_we, src_ready;
  logic [NSRC*AW-1:0] src_waddr;
  logic [NSRC*DW-1:0] src_wdata;
  logic               dst_we;
  logic [AW-1:0]      dst_waddr;
  logic               issue_fire;
  logic               retire_we;
  logic [AW-1:0]      retire_waddr;
  logic               flush_all;
  logic [DW-1:0]      rs1_value, rs2_value;
  logic               stall, sb_err;

  id_scoreboard_fwd #(.NREG(NREG), .AW(AW), .DW(DW), .NSRC(NSRC), .CW(CW)) dut (
    .clk(clk), .resetn(resetn), .rs_need(rs_need), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2), .src_valid(src_valid), .src_we(src_we),
    .src_waddr(src_waddr), .src_ready(src_ready), .src_wdata(src_wdata), .dst_we(dst_we),
    .dst_waddr(dst_waddr), .issue_fire(issue_fire), .retire_we(retire_we),
    .retire_waddr(retire_waddr), .flush_all(flush_all), .rs1_value(rs1_value),
    .rs2_value(rs2_value), .stall(stall), .sb_err(sb_err)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;
  int pend_m [NREG];
  bit err_m;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: youngest matching source if any, else the regfile; pending writers block.
  function automatic void model_port(input logic [AW-1:0] addr, input logic need,
                                     input logic [DW-1:0] rf, output logic [DW-1:0] val,
                                     output logic blk);
`ifdef SB_FWD_EN
    int sel;
    sel = -1;
    for (int i = 0; i < NSRC; i++)
      if (sel < 0 && src_valid[i] && src_we[i] && src_waddr[i*AW +: AW] == addr) sel = i;
    if (addr == 0) begin
      val = '0; blk = 1'b0;
    end else if (sel >= 0) begin
      val = src_wdata[sel*DW +: DW];
      blk = need && !src_ready[sel];
    end else begin
      val = rf;
      blk = need && (pend_m[addr] != 0);
    end
`else
    val = rf;
    blk = need && (addr != 0) && (pend_m[addr] != 0);
`endif
  endfunction

  function automatic void model_eval(output logic [DW-1:0] v1, output logic [DW-1:0] v2,
                                     output logic st);
    logic b1, b2;
    model_port(rs1_addr, rs_need[0], rf_rdata1, v1, b1);
    model_port(rs2_addr, rs_need[1], rf_rdata2, v2, b2);
    st = b1 || b2 || (dst_we && dst_waddr != 0 && pend_m[dst_waddr] == PMAX);
  endfunction

  function automatic void bump(input int r, input int delta);
    if (r == 0) return;
    if (delta > 0) begin
      if (pend_m[r] == PMAX) err_m = 1'b1; else pend_m[r]++;
    end else begin
      if (pend_m[r] == 0) err_m = 1'b1; else pend_m[r]--;
    end
  endfunction

  function automatic void model_clock();
    bit inc, dec;
    if (!resetn) begin
      foreach (pend_m[r]) pend_m[r] = 0;
      err_m = 1'b0;
    end else if (flush_all) begin
      foreach (pend_m[r]) pend_m[r] = 0;
    end else begin
      inc = issue_fire && dst_we;
      dec = retire_we;
      if (inc && dec && dst_waddr == retire_waddr) begin
        // a same-register issue and retire cancel out
      end else begin
        if (inc) bump(int'(dst_waddr), 1);
        if (dec) bump(int'(retire_waddr), -1);
      end
    end
  endfunction

  task automatic step(input string tag);
    logic [DW-1:0] v1, v2;
    logic st;
    #1;
    model_eval(v1, v2, st);
    check($sformatf("%s.rs1", tag), rs1_value, v1);
    check($sformatf("%s.rs2", tag), rs2_value, v2);
    check($sformatf("%s.stall", tag), 32'(stall), 32'(st));
    check($sformatf("%s.sb_err", tag), 32'(sb_err), 32'(err_m));
    if (issue_fire && st && resetn)
      $display("note: illegal issue_fire while stalled at %s", tag);
    @(posedge clk);
    model_clock();
    @(negedge clk);
  endtask

  task automatic idle();
    resetn = 1'b1; rs_need = '0; rs1_addr = '0; rs2_addr = '0;
    rf_rdata1 = '0; rf_rdata2 = '0; src_valid = '0; src_we = '0; src_ready = '0;
    src_waddr = '0; src_wdata = '0; dst_we = 1'b0; dst_waddr = '0; issue_fire = 1'b0;
    retire_we = 1'b0; retire_waddr = '0; flush_all = 1'b0;
  endtask

  task automatic set_src(input int i, input logic [AW-1:0] a, input logic rdy, input logic [DW-1:0] d);
    src_valid[i] = 1'b1; src_we[i] = 1'b1; src_ready[i] = rdy;
    src_waddr[i*AW +: AW] = a; src_wdata[i*DW +: DW] = d;
  endtask

  task automatic issue_to(input logic [AW-1:0] a, input string tag);
    idle(); dst_we = 1'b1; dst_waddr = a; issue_fire = 1'b1;
    step(tag);
  endtask

  task automatic rand_cycle();
    logic [DW-1:0] v1, v2;
    logic st;
    int r;
    rs_need   = 2'($urandom);
    rs1_addr  = AW'($urandom_range(0, 7));
    rs2_addr  = AW'($urandom_range(0, 7));
    rf_rdata1 = $urandom;
    rf_rdata2 = $urandom;
    src_valid = NSRC'($urandom);
    src_we    = NSRC'($urandom);
    src_ready = NSRC'($urandom);
    for (int i = 0; i < NSRC; i++) begin
      src_waddr[i*AW +: AW] = AW'($urandom_range(0, 7));
      src_wdata[i*DW +: DW] = $urandom;
    end
    dst_we    = 1'($urandom);
    dst_waddr = AW'($urandom_range(0, 7));
    r = $urandom_range(1, 7);
    retire_waddr = AW'(r);
    retire_we = (pend_m[r] != 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 199) == 0);
    flush_all = ($urandom_range(0, 59) == 0);
    issue_fire = 1'b0;
    #0;
    model_eval(v1, v2, st);
    issue_fire = 1'($urandom) && !st;
  endtask

  initial begin
    idle();
    resetn = 1'b0;
    repeat (2) @(posedge clk);
    foreach (pend_m[r]) pend_m[r] = 0;
    err_m = 1'b0;
    @(negedge clk);
    resetn = 1'b1;

    rs_need = 2'b11; rs1_addr = 5; rs2_addr = 5; rf_rdata1 = 32'h11; rf_rdata2 = 32'h11;
    #1;
    check("reset_rs1_value", rs1_value, 32'h11);
    check("reset_stall", 32'(stall), 32'd0);
    check("reset_sb_err", 32'(sb_err), 32'd0);
    step("reset_read");

    issue_to(5, "issue_r5");
    idle(); rs_need = 2'b01; rs1_addr = 5; rf_rdata1 = 32'h11;
    set_src(0, 5, 1'b1, 32'hAB); set_src(2, 5, 1'b1, 32'h77);
    step("youngest_wins");

    idle(); set_src(0, 7, 1'b0, 32'hC0DE); rs1_addr = 7; rs_need = 2'b01;
    step("load_use_need");
    rs_need = 2'b00;
    step("load_use_noneed");

    issue_to(9, "div_issue");
    idle(); rs_need = 2'b01; rs1_addr = 9; rf_rdata1 = 32'h99;
    step("div_wait0");
    #1 check("div_wait_stall", 32'(stall), 32'd1);
    retire_we = 1'b1; retire_waddr = 9;
    step("div_retire");
    retire_we = 1'b0;
    #1 check("div_done_stall", 32'(stall), 32'd0);
    step("div_done");
    retire_we = 1'b1; retire_waddr = 9;
    step("div_bad_retire");
    retire_we = 1'b0;
    #1 check("sb_err_set", 32'(sb_err), 32'd1);
    step("sb_err_sticky0");
    step("sb_err_sticky1");

    repeat (3) issue_to(3, "sat_issue");
    idle(); dst_we = 1'b1; dst_waddr = 3;
    #1 check("sat_dst_stall", 32'(stall), 32'd1);
    step("sat_hold");
    issue_fire = 1'b1; retire_we = 1'b1; retire_waddr = 3;
    step("sat_inc_dec");
    issue_fire = 1'b0; retire_we = 1'b0;
    step("sat_after");

    issue_to(9, "pre_flush_r9");
    idle(); flush_all = 1'b1;
    step("flush");
    idle(); rs_need = 2'b11; rs1_addr = 3; rs2_addr = 9; dst_we = 1'b1; dst_waddr = 3;
    #1 check("post_flush_stall", 32'(stall), 32'd0);
    step("post_flush");

    issue_to(9, "interlock_issue");
    idle(); rs_need = 2'b01; rs1_addr = 9; rf_rdata1 = 32'h1234; set_src(0, 9, 1'b1, 32'h55);
    step("src_ready_pending");
    idle(); rs1_addr = 0; rs2_addr = 0; rs_need = 2'b11; set_src(0, 0, 1'b0, 32'h66);
    step("zero_reg");

    idle(); resetn = 1'b0;
    step("reset_mid");
    idle();
    step("after_reset");

    repeat (1500) begin
      rand_cycle();
      step("rand");
    end

    idle(); resetn = 1'b0; rs_need = 2'b11; rs1_addr = 3; rs2_addr = 5;
    step("final_reset");
    resetn = 1'b1;
    #1 check("final_reset_sb_err", 32'(sb_err), 32'd0);
    check("final_reset_stall", 32'(stall), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/id_scoreboard_fwd.md
Name: id_scoreboard_fwd

Overview:
- Parametrised register-hazard unit for the decode stage.
- Replaces the fixed three-source exe/mem/wb compare with NSRC ordered forwarding sources.
- Adds a per-register in-flight writer scoreboard, so producers outside the forwarding sources (multi-cycle mul/div, future units) interlock correctly.
- Sits between the decode logic, the regfile read ports and the EXE/MEM/WB forwarding buses.

Parameters:
- NREG, 32: architectural register count; register 0 is hardwired zero.
- AW, 5: register address width, equal to log2(NREG).
- DW, 32: data width.
- NSRC, 3: number of forwarding sources; index 0 is the youngest (EXE), index NSRC-1 the oldest (WB).
- CW, 2: per-register pending-counter width; at most 2^CW-1 writers may be in flight to one register.

Ports:
- clk  in  1  clock
- resetn  in  1  reset, synchronous, active-low
- rs_need  in  2  bit0: read port 1 is used; bit1: read port 2 is used
- rs1_addr  in  AW  read port 1 address (rj)
- rs2_addr  in  AW  read port 2 address (rk or rd)
- rf_rdata1  in  DW  regfile data for rs1_addr
- rf_rdata2  in  DW  regfile data for rs2_addr
- src_valid  in  NSRC  forwarding source valid
- src_we  in  NSRC  source writes the regfile
- src_waddr  in  NSRC*AW  source destination; slice i is [i*AW +: AW]
- src_ready  in  NSRC  source data is final (0 for a load in EXE or a div not yet done)
- src_wdata  in  NSRC*DW  source result
- dst_we  in  1  instruction in ID writes a register
- dst_waddr  in  AW  its destination
- issue_fire  in  1  ID-to-EXE handshake completes this cycle (id_to_exe_valid & exe_allowin)
- retire_we  in  1  regfile write this cycle
- retire_waddr  in  AW  regfile write address
- flush_all  in  1  every in-flight writer has been killed
- rs1_value  out  DW  resolved operand 1
- rs2_value  out  DW  resolved operand 2
- stall  out  1  ID must not fire (drives id_ready_go low)
- sb_err  out  1  sticky scoreboard error flag

Behaviour:
- State: pend[1..NREG-1], each CW bits; reset value 0. Register 0 has no counter. sb_err resets to 0.
- All outputs except sb_err are combinational from inputs and pend; a counter update is visible on the next cycle.
- Counter update each cycle for register r != 0:
  - inc = issue_fire & dst_we & dst_waddr==r
  - dec = retire_we & retire_waddr==r
  - inc and dec together: unchanged.
  - inc only: +1. dec only: -1.
  - dec with pend==0: counter held at 0 and sb_err set.
  - inc with pend==max: cannot occur, because the stall rule blocks it; if it is forced anyway, the counter saturates and sb_err is set.
- flush_all has priority over inc/dec: all pend cleared the next cycle. sb_err is unaffected.
- Address 0 is never counted, never stalls, and reads value 0.
- Per read port p, match_i = src_valid[i] & src_we[i] & src_waddr_i==addr_p & addr_p!=0. The selected source is the lowest-index i with match_i (youngest wins).
  - Selected source with src_ready=1: value = src_wdata_i and the port is satisfied.
  - Selected source with src_ready=0: the port blocks.
  - No match and pend[addr_p]!=0: the port blocks (untracked producer in flight).
  - No match and pend==0: value = rf_rdata_p.
  - A port with rs_need bit 0 never blocks. Its value is still produced by the same mux.
- stall = block_1 | block_2 | (dst_we & dst_waddr!=0 & pend[dst_waddr]==2^CW-1).
- issue_fire asserted together with stall is illegal. The bench flags it; the RTL still performs the increment.
- Reset mid-operation: counters and sb_err clear on the first clk edge with resetn=0.

Optional Feature:
- Macro: SB_FWD_EN.
- Defined: forwarding exactly as above.
- Undefined: pure interlock.
  - rsN_value = rf_rdataN always.
  - A needed port blocks whenever pend[addr]!=0; src_* inputs are ignored.
  - The dst saturation stall is unchanged.
  - The regfile must write before read (write-through) or the retire cycle still stalls: pend is decremented only on the following edge, so the port blocks in the retire cycle.

Test Plan:
- After reset, read r5 with both ports needed: pend=0, rf_rdata1=0x11 -> rs1_value=0x11, stall=0, sb_err=0.
- Issue add to r5 (issue_fire, dst r5). Next cycle src0 valid/we/waddr=5/ready=1/data=0xAB, and src2 also matches r5 with 0x77 -> rs1_value=0xAB (youngest wins), stall=0.
- Load-use: src0 matches r7 with src_ready=0, rs_need=01, rs1_addr=7 -> stall=1. Same stimulus with rs_need=00 -> stall=0.
- Div in flight: issue to r9, no source matches r9 -> stall=1 until retire_we r9. One cycle after the retire, pend=0 and stall=0. Retire r9 again -> sb_err=1 and stays 1.
- Saturation with CW=2: three issues to r3 without retire -> pend=3. With dst r3 in ID -> stall=1. Issue and retire r3 in the same cycle -> pend stays 3.
- flush_all with pend[3]=3 and pend[9]=1 -> next cycle all counters 0 and no stall. Repeat with SB_FWD_EN undefined: a matching src0 with ready=1 and pend=1 still gives stall=1.
